// File: rtl/rxstr_match_pkg.sv
// rtl/rxstr_match_pkg.sv - shared constants and types for the keyword receiver
package rxstr_match_pkg;

    localparam int B115200 = 104;

    localparam logic [7:0] CHAR_A  = 8'h41;
    localparam logic [3:0] KW_LAST = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_e;

endpackage

// File: rtl/rxstr_match_uart_rx.sv
// rtl/rxstr_match_uart_rx.sv - 8N1 UART receiver with synchronizer and mid-bit sampling
module uart_rx
    import rxstr_match_pkg::*;
#(
    parameter int BAUDRATE = B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr
);

    localparam int CW = $clog2(BAUDRATE) + 1;
    localparam logic [CW-1:0] C_FULL = CW'(BAUDRATE);
    localparam logic [CW-1:0] C_HALF = CW'(BAUDRATE / 2);

    logic [1:0]      r_sync;
    logic            r_hist;
    logic [2:0]      r_warm;
    rx_state_e       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_rcv;
    logic            r_ferr;

    logic w_rx;
    logic w_start;
    logic w_expire;

    assign w_rx     = r_sync[1];
    // The history flop only holds a real line sample once r_warm is full, so a
    // line held low across reset release never looks like a falling edge.
    assign w_start  = r_warm[2] & r_hist & ~w_rx;
    assign w_expire = (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync  <= 2'b11;
            r_hist  <= 1'b1;
            r_warm  <= 3'b000;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_rcv   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx};
            r_hist <= w_rx;
            r_warm <= {r_warm[1:0], 1'b1};
            r_rcv  <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt   <= C_HALF;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_expire) begin
                        if (w_rx) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= C_FULL;
                            r_bit   <= 3'd0;
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_expire) begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_cnt   <= C_FULL;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_expire) begin
                        if (w_rx) begin
                            r_data <= r_shift;
                            r_rcv  <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data = r_data;
    assign rcv  = r_rcv;
    assign ferr = r_ferr;

endmodule

// File: rtl/rxstr_match.sv
// rtl/rxstr_match.sv - UART receiver plus "Alhambra" keyword matcher
module rxstr_match
    import rxstr_match_pkg::*;
#(
    parameter int BAUDRATE = B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic [3:0] progress,
    output logic       match
);

    // Index 0 ('A') sits in the top byte of the packed string literal.
    localparam logic [63:0] KEYWORD = "Alhambra";

    logic [7:0] w_data;
    logic       w_rcv;
    logic       w_ferr;
    logic [5:0] w_kw_lsb;
    logic [7:0] w_kw_char;

    logic [3:0] r_progress;
    logic       r_match;

    uart_rx #(
        .BAUDRATE (BAUDRATE)
    ) u_uart_rx (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .data (w_data),
        .rcv  (w_rcv),
        .ferr (w_ferr)
    );

    assign w_kw_lsb  = {3'd7 - r_progress[2:0], 3'b000};
    assign w_kw_char = KEYWORD[w_kw_lsb +: 8];

    // 'A' occurs only at index 0, so a mismatch restarts at 1 or 0 exactly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_progress <= 4'd0;
            r_match    <= 1'b0;
        end else begin
            r_match <= 1'b0;
            if (w_rcv) begin
                if (w_data == w_kw_char) begin
                    if (r_progress == KW_LAST) begin
                        r_match    <= 1'b1;
                        r_progress <= 4'd0;
                    end else begin
                        r_progress <= r_progress + 4'd1;
                    end
                end else begin
                    r_progress <= (w_data == CHAR_A) ? 4'd1 : 4'd0;
                end
            end
        end
    end

    assign data     = w_data;
    assign rcv      = w_rcv;
    assign ferr     = w_ferr;
    assign progress = r_progress;
    assign match    = r_match;

endmodule

// File: tb/tb_rxstr_match.sv
// tb/tb_rxstr_match.sv - directed bench for the UART keyword matcher
module tb_rxstr_match;

    localparam int BAUD = 104;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;
    logic [3:0] progress;
    logic       match;

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    int rcv_cnt = 0, ferr_cnt = 0, match_cnt = 0, match_bad = 0, overlap = 0;
    logic       prev_rcv  = 1'b0;
    logic [7:0] last_byte = 8'h00;
    logic [7:0] byte_q[$];
    logic [3:0] prog_q[$];

    int r0, f0, m0;

    rxstr_match #(.BAUDRATE(BAUD)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (rx),
        .data     (data),
        .rcv      (rcv),
        .ferr     (ferr),
        .progress (progress),
        .match    (match)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prev_rcv) prog_q.push_back(progress);
        if (match) begin
            match_cnt++;
            if (!(prev_rcv && last_byte == 8'h61 && progress == 4'd0)) match_bad++;
        end
        if (rcv) begin
            rcv_cnt++;
            byte_q.push_back(data);
            last_byte = data;
        end
        if (ferr) ferr_cnt++;
        if (rcv && ferr) overlap++;
        if (match && ferr) overlap++;
        prev_rcv = rcv;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_cycles(BAUD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(BAUD);
        end
        rx = stop;
        wait_cycles(BAUD);
        rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic snap();
        r0 = rcv_cnt;
        f0 = ferr_cnt;
        m0 = match_cnt;
        byte_q.delete();
        prog_q.delete();
    endtask

    initial begin
        logic [7:0] exp_b1[8];
        logic [3:0] exp_p1[8];
        logic [3:0] exp_p2[11];
        exp_b1 = '{8'h41, 8'h6C, 8'h68, 8'h61, 8'h6D, 8'h62, 8'h72, 8'h61};
        exp_p1 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};
        exp_p2 = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};

        rstn = 1'b0;
        rx   = 1'b1;
        wait_cycles(5);
        check("reset_data", 32'(data), 32'h00);
        check("reset_rcv", 32'(rcv), 32'h0);
        check("reset_ferr", 32'(ferr), 32'h0);
        check("reset_match", 32'(match), 32'h0);
        check("reset_progress", 32'(progress), 32'h0);
        rstn = 1'b1;
        wait_cycles(2 * BAUD);

        // Plain keyword
        snap();
        send_str("Alhambra");
        wait_cycles(2 * BAUD);
        check("t1_rcv_count", 32'(rcv_cnt - r0), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_byte%0d", i), 32'(byte_q[i]), 32'(exp_b1[i]));
            check($sformatf("t1_prog%0d", i), 32'(prog_q[i]), 32'(exp_p1[i]));
        end
        check("t1_match_count", 32'(match_cnt - m0), 32'd1);

        // Partial restart on second 'A'
        snap();
        send_str("AlhAlhambra");
        wait_cycles(2 * BAUD);
        check("t2_rcv_count", 32'(rcv_cnt - r0), 32'd11);
        for (int i = 0; i < 11; i++)
            check($sformatf("t2_prog%0d", i), 32'(prog_q[i]), 32'(exp_p2[i]));
        check("t2_match_count", 32'(match_cnt - m0), 32'd1);

        // Framing error in the middle of the keyword
        snap();
        send_str("Alha");
        wait_cycles(BAUD);
        r0 = rcv_cnt;
        send_byte(8'h55, 1'b0);
        wait_cycles(2 * BAUD);
        check("t3_ferr_count", 32'(ferr_cnt - f0), 32'd1);
        check("t3_no_rcv", 32'(rcv_cnt - r0), 32'd0);
        check("t3_data_held", 32'(data), 32'h61);
        check("t3_progress_held", 32'(progress), 32'd4);
        send_str("mbra");
        wait_cycles(2 * BAUD);
        check("t3_match_count", 32'(match_cnt - m0), 32'd1);
        check("t3_progress_end", 32'(progress), 32'd0);

        // Short low glitch on an idle line
        snap();
        rx = 1'b0;
        wait_cycles(20);
        rx = 1'b1;
        wait_cycles(2 * BAUD);
        check("t4_glitch_rcv", 32'(rcv_cnt - r0), 32'd0);
        check("t4_glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        send_byte(8'h5A, 1'b1);
        wait_cycles(2 * BAUD);
        check("t4_rcv_count", 32'(rcv_cnt - r0), 32'd1);
        check("t4_data", 32'(data), 32'h5A);
        check("t4_progress", 32'(progress), 32'd0);

        // Reset partway through the 'r'
        snap();
        send_str("Alhamb");
        check("t5_progress_pre", 32'(progress), 32'd6);
        rx = 1'b0;
        wait_cycles(BAUD);
        rx = 1'b0;
        wait_cycles(BAUD);
        rx = 1'b1;
        wait_cycles(2 * BAUD);
        r0 = rcv_cnt;
        f0 = ferr_cnt;
        m0 = match_cnt;
        rstn = 1'b0;
        wait_cycles(10);
        rx = 1'b1;
        rstn = 1'b1;
        wait_cycles(12 * BAUD);
        check("t5_abort_rcv", 32'(rcv_cnt - r0), 32'd0);
        check("t5_abort_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("t5_abort_match", 32'(match_cnt - m0), 32'd0);
        check("t5_progress_reset", 32'(progress), 32'd0);
        check("t5_data_reset", 32'(data), 32'h00);
        send_str("Alhambra");
        wait_cycles(2 * BAUD);
        check("t5_resend_rcv", 32'(rcv_cnt - r0), 32'd8);
        check("t5_resend_match", 32'(match_cnt - m0), 32'd1);

        // Line held low across reset release
        snap();
        rstn = 1'b0;
        rx   = 1'b0;
        wait_cycles(5);
        rstn = 1'b1;
        wait_cycles(12 * BAUD);
        check("t6_low_rcv", 32'(rcv_cnt - r0), 32'd0);
        check("t6_low_ferr", 32'(ferr_cnt - f0), 32'd0);
        rx = 1'b1;
        wait_cycles(2 * BAUD);
        send_byte(8'h41, 1'b1);
        wait_cycles(2 * BAUD);
        check("t6_rcv_count", 32'(rcv_cnt - r0), 32'd1);
        check("t6_data", 32'(data), 32'h41);
        check("t6_progress", 32'(progress), 32'd1);

        check("match_timing", 32'(match_bad), 32'd0);
        check("pulse_overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
